key_event_gen: RTL and testbench

- Sits directly downstream of the keyboard decoder that turns the 32-bit USB keycode into per-key pressed levels.
- Converts those 13 level signals into one-clock key event pulses for the game logic: one event on press, then auto-repeat while held.
- Only keys selected by a mask auto-repeat.
- Repeat timing counts frame ticks (one per video frame), so repeat rate is independent of system clock frequency.

---
 rtl/key_event_gen_if.sv | 58 +++++
 rtl/key_event_gen.sv | 184 ++++++++++++++++++
 tb/tb_key_event_gen.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/key_event_gen_if.sv
// key_event_gen_if
//   Bundles the key-level inputs and the key-event outputs of key_event_gen.
//   Clk and Reset are not part of the bundle and stay plain ports on the module.
//
//   Signals:
//     key_pressed  [NUM_KEYS]  per-key pressed level coming from the keyboard decoder
//     frame_tick               single-cycle pulse, once per video frame
//     key_event    [NUM_KEYS]  one-clock pulse per press or repeat, per lane
//     any_event                OR of key_event, in the same cycle as key_event
//     key_release  [NUM_KEYS]  one-clock release pulse, per lane
//                              (present only when KEY_RELEASE_EVT_EN is defined)
//
//   Modports:
//     master  the keyboard decoder / game side: drives the levels and the tick, and
//             consumes the events
//     slave   key_event_gen: takes the levels and the tick, and produces the events
`timescale 1ns/1ps
interface key_event_gen_if #(
  parameter int unsigned NUM_KEYS = 13
);
  logic [NUM_KEYS-1:0] key_pressed;
  logic                frame_tick;
  logic [NUM_KEYS-1:0] key_event;
  logic                any_event;
`ifdef KEY_RELEASE_EVT_EN
  logic [NUM_KEYS-1:0] key_release;

  modport master (
    output key_pressed,
    output frame_tick,
    input  key_event,
    input  any_event,
    input  key_release
  );

  modport slave (
    input  key_pressed,
    input  frame_tick,
    output key_event,
    output any_event,
    output key_release
  );
`else
  modport master (
    output key_pressed,
    output frame_tick,
    input  key_event,
    input  any_event
  );

  modport slave (
    input  key_pressed,
    input  frame_tick,
    output key_event,
    output any_event
  );
`endif
endinterface

// File: rtl/key_event_gen.sv
// key_event_gen
//   Turns per-key pressed levels into one-clock key event pulses for the game
//   logic. A key produces one event when it is pressed. Lanes selected by
//   REPEAT_MASK also auto-repeat while the key stays held: the first repeat
//   comes REPEAT_DELAY frame ticks after the press event, and later repeats come
//   every REPEAT_PERIOD frame ticks. Repeat timing counts frame ticks, not clocks.
//
//   Optional feature (macro KEY_RELEASE_EVT_EN): adds the key_release output,
//   a one-clock pulse the cycle after a held key is seen released.
//
//   Ports:
//     Clk    system clock
//     Reset  synchronous, active-high reset
//     bus    key_event_gen_if.slave: key_pressed, frame_tick in;
//            key_event, any_event (and key_release) out
//
//   Lane map: 0 w, 1 s, 2 a, 3 d, 4 up, 5 down, 6 left, 7 right, 8 enter,
//             9 space, 10 keypad-0, 11 r, 12 backspace.
`timescale 1ns/1ps
module key_event_gen #(
  parameter int unsigned          NUM_KEYS      = 13,
  parameter int unsigned          CNT_W         = 8,
  parameter int unsigned          REPEAT_DELAY  = 20,
  parameter int unsigned          REPEAT_PERIOD = 6,
  parameter logic [NUM_KEYS-1:0]  REPEAT_MASK   = 13'h00FF
) (
  input  logic               Clk,
  input  logic               Reset,
  key_event_gen_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOCK   = 3'd1,
    HELD   = 3'd2,
    WAIT   = 3'd3,
    REPEAT = 3'd4
  } state_t;

  // The last counter value before an event fires. Both delays are at least 1
  // and at most 2^CNT_W, so these always fit in CNT_W bits.
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  state_t              state_q [NUM_KEYS];
  state_t              state_d [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];

  logic [NUM_KEYS-1:0] event_d;
  logic [NUM_KEYS-1:0] event_q;
  logic                any_q;
`ifdef KEY_RELEASE_EVT_EN
  logic [NUM_KEYS-1:0] release_d;
  logic [NUM_KEYS-1:0] release_q;
`endif

  // State and counter registers, plus the registered event outputs.
  // Reset parks every lane in LOCK so a key held across reset stays silent
  // until it has been released once.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= LOCK;
        cnt_q[i]   <= '0;
      end
      event_q   <= '0;
      any_q     <= 1'b0;
`ifdef KEY_RELEASE_EVT_EN
      release_q <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      event_q   <= event_d;
      any_q     <= |event_d;
`ifdef KEY_RELEASE_EVT_EN
      release_q <= release_d;
`endif
    end
  end

  // Next-state and counter logic, one independent FSM per lane.
  // A release is checked before frame_tick so a release landing on a tick
  // returns to IDLE without counting that tick.
  always_comb begin
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        LOCK: begin
          if (!bus.key_pressed[i]) state_d[i] = IDLE;
        end
        IDLE: begin
          // A frame_tick coinciding with the press is not counted.
          if (bus.key_pressed[i]) begin
            state_d[i] = REPEAT_MASK[i] ? WAIT : HELD;
            cnt_d[i]   = '0;
          end
        end
        HELD: begin
          if (!bus.key_pressed[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        end
        WAIT: begin
          if (!bus.key_pressed[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (bus.frame_tick) begin
            if (cnt_q[i] == DELAY_LAST) begin
              state_d[i] = REPEAT;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
        end
        REPEAT: begin
          if (!bus.key_pressed[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (bus.frame_tick) begin
            if (cnt_q[i] == PERIOD_LAST) begin
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d[i] = LOCK;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Event decode. The results are registered above, so every pulse appears
  // the cycle after the sample that caused it.
  always_comb begin
    event_d = '0;
`ifdef KEY_RELEASE_EVT_EN
    release_d = '0;
`endif
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      case (state_q[i])
        IDLE: begin
          event_d[i] = bus.key_pressed[i];
        end
        HELD: begin
`ifdef KEY_RELEASE_EVT_EN
          release_d[i] = !bus.key_pressed[i];
`endif
        end
        WAIT: begin
          event_d[i] = bus.key_pressed[i] && bus.frame_tick && (cnt_q[i] == DELAY_LAST);
`ifdef KEY_RELEASE_EVT_EN
          release_d[i] = !bus.key_pressed[i];
`endif
        end
        REPEAT: begin
          event_d[i] = bus.key_pressed[i] && bus.frame_tick && (cnt_q[i] == PERIOD_LAST);
`ifdef KEY_RELEASE_EVT_EN
          release_d[i] = !bus.key_pressed[i];
`endif
        end
        default: begin
          event_d[i] = 1'b0;
        end
      endcase
    end
  end

  assign bus.key_event   = event_q;
  assign bus.any_event   = any_q;
`ifdef KEY_RELEASE_EVT_EN
  assign bus.key_release = release_q;
`endif

endmodule

// File: tb/tb_key_event_gen.sv
`timescale 1ns/1ps
module tb_key_event_gen;

  localparam int unsigned NK = 13;

  logic Clk;
  logic Reset;

  int checks;
  int failures;
  int ev_count [NK];
  int any_count;

  key_event_gen_if #(.NUM_KEYS(NK)) bus ();

  key_event_gen #(
    .NUM_KEYS      (NK),
    .CNT_W         (8),
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (6),
    .REPEAT_MASK   (13'h00FF)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1ns after the edge; tallies every pulse seen.
  task automatic cycle();
    @(posedge Clk);
    #1;
    for (int i = 0; i < NK; i++) ev_count[i] += int'(bus.key_event[i]);
    any_count += int'(bus.any_event);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NK; i++) ev_count[i] = 0;
    any_count = 0;
  endtask

  // One frame tick: tick cycle then one quiet cycle.
  task automatic tick();
    bus.frame_tick = 1'b1;
    cycle();
    bus.frame_tick = 1'b0;
    cycle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_counts();
    Reset           = 1'b1;
    bus.key_pressed = '0;
    bus.frame_tick  = 1'b0;

    // Reset for 2 cycles
    cycle();
    cycle();
    chk("reset_key_event", 32'(bus.key_event), 32'h0);
    chk("reset_any_event", 32'(bus.any_event), 32'h0);
    Reset = 1'b0;
    cycle();  // LOCK -> IDLE with nothing pressed

    // Enter (lane 8, no repeat) held for 50 ticks: a single event
    bus.key_pressed = 13'h0100;
    cycle();
    chk("enter_press_evt", 32'(bus.key_event), 32'h0100);
    chk("enter_press_any", 32'(bus.any_event), 32'h1);
    clear_counts();
    for (int k = 0; k < 50; k++) tick();
    chk("enter_no_repeat", 32'(ev_count[8]), 32'd0);
    chk("enter_any_quiet", 32'(any_count), 32'd0);
    bus.key_pressed = '0;
    cycle();

    // Left (lane 6) held for 38 ticks: repeats after ticks 20, 26, 32, 38
    bus.key_pressed = 13'h0040;
    cycle();
    chk("left_press_evt", 32'(bus.key_event), 32'h0040);
    clear_counts();
    for (int k = 1; k <= 38; k++) begin
      bus.frame_tick = 1'b1;
      cycle();
      if (k == 20 || k == 26 || k == 32 || k == 38)
        chk("left_repeat_evt", 32'(bus.key_event), 32'h0040);
      bus.frame_tick = 1'b0;
      cycle();
    end
    chk("left_repeat_count", 32'(ev_count[6]), 32'd4);
    chk("left_any_count", 32'(any_count), 32'd4);
    bus.key_pressed = '0;
    cycle();

    // Left released on the 20th tick: release wins; re-press 3 cycles later
    bus.key_pressed = 13'h0040;
    cycle();
    chk("left2_press_evt", 32'(bus.key_event), 32'h0040);
    clear_counts();
    for (int k = 0; k < 19; k++) tick();
    bus.frame_tick  = 1'b1;
    bus.key_pressed = '0;
    cycle();
    chk("left2_release_beats_tick", 32'(bus.key_event), 32'h0);
    bus.frame_tick = 1'b0;
    cycle();
    cycle();
    chk("left2_no_events", 32'(ev_count[6]), 32'd0);
    bus.key_pressed = 13'h0040;
    cycle();
    chk("left2_repress_evt", 32'(bus.key_event), 32'h0040);
    bus.key_pressed = '0;
    cycle();

    // W held into REPEAT, reset mid-repeat, still held: silent until released
    bus.key_pressed = 13'h0001;
    cycle();
    chk("w_press_evt", 32'(bus.key_event), 32'h0001);
    for (int k = 0; k < 22; k++) tick();
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    chk("w_reset_evt", 32'(bus.key_event), 32'h0);
    clear_counts();
    for (int k = 0; k < 40; k++) tick();
    chk("w_locked_count", 32'(ev_count[0]), 32'd0);
    bus.key_pressed = '0;
    cycle();
    chk("w_release_evt", 32'(bus.key_event), 32'h0);
    bus.key_pressed = 13'h0001;
    cycle();
    chk("w_repress_evt", 32'(bus.key_event), 32'h0001);
    bus.key_pressed = '0;
    cycle();

    // W and up pressed together, held 20 ticks
    bus.key_pressed = 13'h0011;
    cycle();
    chk("wup_press_evt", 32'(bus.key_event), 32'h0011);
    clear_counts();
    for (int k = 0; k < 19; k++) tick();
    chk("wup_quiet_count", 32'(any_count), 32'd0);
    bus.frame_tick = 1'b1;
    cycle();
    chk("wup_repeat_evt", 32'(bus.key_event), 32'h0011);
    chk("wup_repeat_any", 32'(bus.any_event), 32'h1);
    bus.frame_tick  = 1'b0;
    bus.key_pressed = '0;
    cycle();

    // Single-cycle press on a repeating lane (d) still gives exactly one event
    bus.key_pressed = 13'h0008;
    cycle();
    chk("d_pulse_evt", 32'(bus.key_event), 32'h0008);
    bus.key_pressed = '0;
    clear_counts();
    for (int k = 0; k < 25; k++) tick();
    chk("d_pulse_count", 32'(ev_count[3]), 32'd0);

    // Tick on the press cycle is not counted: first repeat 20 ticks later
    bus.key_pressed = 13'h0004;
    bus.frame_tick  = 1'b1;
    cycle();
    chk("a_press_tick_evt", 32'(bus.key_event), 32'h0004);
    bus.frame_tick = 1'b0;
    cycle();
    clear_counts();
    for (int k = 0; k < 19; k++) tick();
    chk("a_quiet_19", 32'(ev_count[2]), 32'd0);
    bus.frame_tick = 1'b1;
    cycle();
    chk("a_repeat_20", 32'(bus.key_event), 32'h0004);
    bus.frame_tick  = 1'b0;
    bus.key_pressed = '0;
    cycle();

`ifdef KEY_RELEASE_EVT_EN
    // Space press then release: one release pulse
    bus.key_pressed = 13'h0200;
    cycle();
    chk("space_press_evt", 32'(bus.key_event), 32'h0200);
    chk("space_press_rel", 32'(bus.key_release), 32'h0);
    bus.key_pressed = '0;
    cycle();
    chk("space_release_pulse", 32'(bus.key_release), 32'h0200);
    cycle();
    chk("space_release_once", 32'(bus.key_release), 32'h0);

    // Space held across reset then released: no release pulse
    bus.key_pressed = 13'h0200;
    cycle();
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    cycle();
    bus.key_pressed = '0;
    cycle();
    chk("space_lock_release", 32'(bus.key_release), 32'h0);
    cycle();
    chk("space_lock_release2", 32'(bus.key_release), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
